// File: rtl/led_ctrl_pkg.sv
// Shared definitions for the board LED controllers: FSM states, tick
// prescaler sizing and the per-source blink period field width.
package led_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } led_state_t;

    localparam int unsigned PERIOD_W = 4;

    // Terminal count of the tick prescaler for a given clock and tick period.
    function automatic int unsigned tick_count(input longint unsigned freq,
                                               input longint unsigned ms);
        return 32'(freq * ms / 64'd1000 - 64'd1);
    endfunction

endpackage

// File: rtl/led_tick_prescaler.sv
// Free-running tick divider: one-cycle tick every COUNT_TICK+1 clocks,
// restartable from zero through a synchronous clear.
module led_tick_prescaler #(
    parameter int unsigned COUNT_TICK = 2_699_999
) (
    input  logic Clock,
    input  logic Reset,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CW = (COUNT_TICK > 0) ? $clog2(COUNT_TICK + 1) : 1;

    logic [CW-1:0] count;

    assign tick = (count == CW'(COUNT_TICK));

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            count <= '0;
        end else if (clear || tick) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/led_blink_scheduler.sv
// Round-robin owner of the single board LED: each granted source blinks at
// its own half-period for a minimum hold time, with a one-tick dark gap.
module led_blink_scheduler
    import led_ctrl_pkg::*;
#(
    parameter int unsigned CLOCK_FREQUENCY = 27_000_000,
    parameter int unsigned TICK_MS         = 100,
    parameter int unsigned N_REQ           = 4,
    parameter int unsigned HOLD_TICKS      = 20
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic [N_REQ-1:0]          Req,
    input  logic [PERIOD_W*N_REQ-1:0] Period,
    output logic [N_REQ-1:0]          Grant,
    output logic                      Busy,
    output logic                      IO_voltage
);

    localparam int unsigned COUNT_TICK = tick_count(64'(CLOCK_FREQUENCY), 64'(TICK_MS));
    localparam int unsigned HW         = $clog2(HOLD_TICKS + 1);
    localparam int unsigned LW         = $clog2(N_REQ);

    led_state_t        state, state_n;
    logic [LW-1:0]     last, last_n, win;
    logic [PERIOD_W-1:0] per, per_n, phase, phase_n;
    logic [HW-1:0]     hold, hold_n;
    logic [N_REQ-1:0]  grant_n;
    logic              busy_n, io_n;
    logic              clear, tick;
    logic              hold_done, owner_req, others_req;

    // First set request strictly after 'from', wrapping modulo N_REQ.
    function automatic logic [LW-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                              input logic [LW-1:0]    from);
        logic [LW-1:0] pick;
        int unsigned   idx;
        pick = from;
        for (int unsigned k = N_REQ; k >= 1; k--) begin
            idx = (32'(from) + k) % N_REQ;
            if (req[idx]) pick = LW'(idx);
        end
        return pick;
    endfunction

    led_tick_prescaler #(
        .COUNT_TICK(COUNT_TICK)
    ) u_prescaler (
        .Clock(Clock),
        .Reset(Reset),
        .clear(clear),
        .tick (tick)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            Grant      <= '0;
            Busy       <= 1'b0;
            IO_voltage <= 1'b0;
            last       <= LW'(N_REQ - 1);
            per        <= '0;
            phase      <= '0;
            hold       <= '0;
        end else begin
            state      <= state_n;
            Grant      <= grant_n;
            Busy       <= busy_n;
            IO_voltage <= io_n;
            last       <= last_n;
            per        <= per_n;
            phase      <= phase_n;
            hold       <= hold_n;
        end
    end

    always_comb begin
        state_n    = state;
        grant_n    = Grant;
        busy_n     = Busy;
        io_n       = IO_voltage;
        last_n     = last;
        per_n      = per;
        phase_n    = phase;
        hold_n     = hold;
        clear      = 1'b0;
        win        = rr_pick(Req, last);
        hold_done  = (hold == HW'(HOLD_TICKS));
        owner_req  = |(Req & Grant);
        others_req = |(Req & ~Grant);

        case (state)
            IDLE: begin
                clear = 1'b1;
                if (|Req) begin
                    state_n = SHOW;
                    grant_n = N_REQ'(1) << win;
                    last_n  = win;
                    per_n   = Period[PERIOD_W*win +: PERIOD_W];
                    busy_n  = 1'b1;
                    io_n    = 1'b1;
                    phase_n = '0;
                    hold_n  = '0;
                end
            end
            SHOW: begin
                // Exit wins over a coincident tick: GAP forces the LED dark anyway.
                if (hold_done && (!owner_req || others_req)) begin
                    state_n = GAP;
                    grant_n = '0;
                    io_n    = 1'b0;
                    clear   = 1'b1;
                end else if (tick) begin
                    if (!hold_done) hold_n = hold + HW'(1);
                    if (per != '0) begin
                        if (phase == per - PERIOD_W'(1)) begin
                            phase_n = '0;
                            io_n    = ~IO_voltage;
                        end else begin
                            phase_n = phase + PERIOD_W'(1);
                        end
                    end
                end
            end
            GAP: begin
                if (tick) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_led_blink_scheduler.sv
// Bench for led_blink_scheduler: vector table, hand-written corner sequences
// and randomized traffic against a timestamp-based reference model.
module tb_led_blink_scheduler;

    localparam int CPT  = 10;   // clock cycles per tick
    localparam int HOLD = 4;
    localparam int NR   = 4;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [3:0]  Req = '0;
    logic [15:0] Period = '0;
    logic [3:0]  Grant;
    logic        Busy;
    logic        IO_voltage;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned n_prints = 0;

    led_blink_scheduler #(
        .CLOCK_FREQUENCY(10_000),
        .TICK_MS        (1),
        .N_REQ          (4),
        .HOLD_TICKS     (4)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Req       (Req),
        .Period    (Period),
        .Grant     (Grant),
        .Busy      (Busy),
        .IO_voltage(IO_voltage)
    );

    always #5 Clock = ~Clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        bit          rst;
        logic [3:0]  req;
        logic [15:0] period;
        int          n;
        logic [3:0]  g;
        logic        b;
        logic        io;
        string       name;
    } vec_t;

    vec_t vecs[$];

    // Reference model: mode 0 idle, 1 showing, 2 gap; m_t counts edges in mode.
    int m_mode, m_owner, m_last, m_per, m_t;

    function automatic void model_reset();
        m_mode = 0; m_owner = 0; m_last = NR - 1; m_per = 0; m_t = 0;
    endfunction

    function automatic void model_edge();
        bit found;
        int idx;
        case (m_mode)
            0: if (Req != 4'b0) begin
                found = 0;
                for (int i = 1; i <= NR; i++) begin
                    idx = (m_last + i) % NR;
                    if (!found && Req[idx]) begin
                        m_owner = idx;
                        found   = 1;
                    end
                end
                m_last = m_owner;
                m_per  = (int'(Period) >> (4 * m_owner)) & 15;
                m_mode = 1;
                m_t    = 0;
            end
            1: begin
                if (m_t >= HOLD * CPT &&
                    (!Req[m_owner] || (Req & ~(4'b0001 << m_owner)) != 4'b0)) begin
                    m_mode = 2;
                    m_t    = 0;
                end else begin
                    m_t++;
                end
            end
            default: begin
                if (m_t == CPT - 1) m_mode = 0;
                else m_t++;
            end
        endcase
    endfunction

    function automatic logic [3:0] model_grant();
        return (m_mode == 1) ? 4'(1 << m_owner) : 4'b0;
    endfunction

    function automatic logic model_io();
        if (m_mode != 1) return 1'b0;
        if (m_per == 0) return 1'b1;
        return ((m_t / (m_per * CPT)) % 2) == 0;
    endfunction

    task automatic check(input string name, input logic [3:0] g, input logic b, input logic io);
        n_checks++;
        if (Grant === g && Busy === b && IO_voltage === io) begin
            n_pass++;
        end else if (n_prints < 30) begin
            n_prints++;
            $display("FAIL %s @%0t: got Grant=%b Busy=%b IO=%b, expected Grant=%b Busy=%b IO=%b",
                     name, $time, Grant, Busy, IO_voltage, g, b, io);
        end
    endtask

    task automatic do_reset();
        @(negedge Clock);
        Reset  = 1'b1;
        Req    = '0;
        Period = '0;
        #2;
        check("reset", 4'b0000, 1'b0, 1'b0);
        @(negedge Clock);
        Reset = 1'b0;
        model_reset();
    endtask

    task automatic add(input bit rst, input logic [3:0] req, input logic [15:0] period,
                       input int n, input logic [3:0] g, input logic b, input logic io,
                       input string name);
        vec_t v;
        v.rst = rst; v.req = req; v.period = period; v.n = n;
        v.g = g; v.b = b; v.io = io; v.name = name;
        vecs.push_back(v);
    endtask

    initial begin
        int bad;

        // Sole owner, half-period 2 ticks: toggles every 20 cycles, never released.
        add(1, 4'b0000, 16'h0000,   0, 4'b0000, 0, 0, "rst_a");
        add(0, 4'b0001, 16'h0002,   1, 4'b0001, 1, 1, "a_grant");
        add(0, 4'b0001, 16'h0002,  19, 4'b0001, 1, 1, "a_pre_toggle");
        add(0, 4'b0001, 16'h0002,   1, 4'b0001, 1, 0, "a_toggle1");
        add(0, 4'b0001, 16'h0002,  20, 4'b0001, 1, 1, "a_toggle2");
        add(0, 4'b0001, 16'h0002, 100, 4'b0001, 1, 0, "a_kept");
        // Two contenders alternate with a gap between owners.
        add(1, 4'b0000, 16'h0000,   0, 4'b0000, 0, 0, "rst_b");
        add(0, 4'b0101, 16'h0301,   1, 4'b0001, 1, 1, "b_grant0");
        add(0, 4'b0101, 16'h0301,  40, 4'b0001, 1, 1, "b_hold_end");
        add(0, 4'b0101, 16'h0301,   1, 4'b0000, 1, 0, "b_gap");
        add(0, 4'b0101, 16'h0301,   9, 4'b0000, 1, 0, "b_gap_last");
        add(0, 4'b0101, 16'h0301,   1, 4'b0000, 0, 0, "b_idle");
        add(0, 4'b0101, 16'h0301,   1, 4'b0100, 1, 1, "b_grant2");
        add(0, 4'b0101, 16'h0301,  30, 4'b0100, 1, 0, "b_toggle2");
        add(0, 4'b0101, 16'h0301,  11, 4'b0000, 1, 0, "b_gap2");
        add(0, 4'b0101, 16'h0301,  10, 4'b0000, 0, 0, "b_idle2");
        add(0, 4'b0101, 16'h0301,   1, 4'b0001, 1, 1, "b_back_to0");
        // Owner drops its request after tick 1: minimum hold still served.
        add(1, 4'b0000, 16'h0000,   0, 4'b0000, 0, 0, "rst_c");
        add(0, 4'b0001, 16'h0001,   1, 4'b0001, 1, 1, "c_grant");
        add(0, 4'b0001, 16'h0001,  10, 4'b0001, 1, 0, "c_tick1");
        add(0, 4'b0000, 16'h0001,  10, 4'b0001, 1, 1, "c_dropped");
        add(0, 4'b0000, 16'h0001,  20, 4'b0001, 1, 1, "c_tick4");
        add(0, 4'b0000, 16'h0001,   1, 4'b0000, 1, 0, "c_gap");
        add(0, 4'b0000, 16'h0001,  10, 4'b0000, 0, 0, "c_idle");

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) begin
                do_reset();
            end else begin
                Req    = vecs[i].req;
                Period = vecs[i].period;
                repeat (vecs[i].n) @(negedge Clock);
                check(vecs[i].name, vecs[i].g, vecs[i].b, vecs[i].io);
            end
        end

        // Steady-on owner; a Period change mid-SHOW must not start blinking.
        do_reset();
        Req    = 4'b0010;
        Period = 16'h0000;
        @(negedge Clock);
        check("p0_grant", 4'b0010, 1'b1, 1'b1);
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            if (i == 10) Period = 16'h0010;
            @(negedge Clock);
            if (IO_voltage !== 1'b1 || Grant !== 4'b0010) bad++;
        end
        n_checks++;
        if (bad == 0) n_pass++;
        else $display("FAIL p0_steady: %0d cycles not lit by source 1, expected 0", bad);

        // Asynchronous reset between clock edges mid-SHOW.
        do_reset();
        Req    = 4'b1111;
        Period = 16'h1111;
        repeat (6) @(negedge Clock);
        check("e_pre_reset", 4'b0001, 1'b1, 1'b1);
        @(posedge Clock);
        #3;
        Reset = 1'b1;
        #1;
        check("e_async_reset", 4'b0000, 1'b0, 1'b0);
        @(negedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
        check("e_restart", 4'b0001, 1'b1, 1'b1);

        // Request arriving in the last GAP cycle is picked up from IDLE.
        do_reset();
        Req    = 4'b0001;
        Period = 16'h0001;
        repeat (11) @(negedge Clock);
        Req = 4'b0000;
        repeat (40) @(negedge Clock);
        check("f_gap_last", 4'b0000, 1'b1, 1'b0);
        Req = 4'b1000;
        @(negedge Clock);
        check("f_idle", 4'b0000, 1'b0, 1'b0);
        @(negedge Clock);
        check("f_grant3", 4'b1000, 1'b1, 1'b1);

        // Randomized traffic against the reference model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 15) == 0) Req = 4'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                for (int s = 0; s < NR; s++)
                    Period[4*s +: 4] = 4'($urandom_range(0, 3));
            end
            @(posedge Clock);
            model_edge();
            @(negedge Clock);
            check("random", model_grant(), m_mode != 0, model_io());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
